// File: rtl/pattern_serializer.sv
// Streams a run of bytes read from pattern_ram onto one serial line, MSB first,
// holding each bit for a programmable number of clocks and prefetching the next byte.
module pattern_serializer #(
  parameter int   DATA_BIT   = 8,
  parameter int   ADDR_BIT   = 8,
  parameter int   DIV_BIT    = 16,
  parameter int   RD_LATENCY = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_BIT-1:0] base_addr_i,
  input  logic [ADDR_BIT-1:0] len_i,
  input  logic [DIV_BIT-1:0]  divisor_i,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  input  logic [DATA_BIT-1:0] ram_q_i,
  output logic                serial_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int LAT_W = 3;
  localparam int BIT_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t              state, state_next;
  logic [LAT_W-1:0]    fetch_cnt, pf_cnt;
  logic                pf_pend;
  logic [DIV_BIT-1:0]  div_val, div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [ADDR_BIT-1:0] byte_cnt;
  logic [DATA_BIT-1:0] shreg, nbuf;

  logic start_ok, fetch_rdy, pf_take, bit_end, byte_end, last_end;

  // A zero divisor would never end a bit period, so it is promoted to one.
  function automatic logic [DIV_BIT-1:0] clamp_div(input logic [DIV_BIT-1:0] d);
    return (d == '0) ? DIV_BIT'(1) : d;
  endfunction

  assign start_ok  = start_i && !done_o;
  assign fetch_rdy = (fetch_cnt == LAT_W'(RD_LATENCY));
  assign pf_take   = pf_pend && (pf_cnt == LAT_W'(RD_LATENCY));
  assign bit_end   = (div_cnt == div_val - DIV_BIT'(1));
  assign byte_end  = bit_end && (bit_cnt == '0);
  assign last_end  = byte_end && (byte_cnt == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok && len_i != '0) state_next = FETCH;
      FETCH:   if (fetch_rdy) state_next = SHIFT;
      SHIFT:   if (last_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Control: counters, address, serial line and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      pf_cnt     <= '0;
      pf_pend    <= 1'b0;
      div_val    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      ram_addr_o <= '0;
      serial_o   <= IDLE_LEVEL;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          fetch_cnt <= '0;
          if (start_ok) begin
            if (len_i != '0) begin
              ram_addr_o <= base_addr_i;
              byte_cnt   <= len_i - ADDR_BIT'(1);
              div_val    <= clamp_div(divisor_i);
              busy_o     <= 1'b1;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (fetch_rdy) begin
            serial_o   <= ram_q_i[DATA_BIT-1];
            ram_addr_o <= ram_addr_o + ADDR_BIT'(1);
            bit_cnt    <= BIT_W'(DATA_BIT - 1);
            div_cnt    <= '0;
            pf_pend    <= 1'b1;
            pf_cnt     <= '0;
          end else begin
            fetch_cnt <= fetch_cnt + LAT_W'(1);
          end
        end
        SHIFT: begin
          if (pf_take)      pf_pend <= 1'b0;
          else if (pf_pend) pf_cnt  <= pf_cnt + LAT_W'(1);
          if (!bit_end) begin
            div_cnt <= div_cnt + DIV_BIT'(1);
          end else begin
            div_cnt <= '0;
            if (!byte_end) begin
              bit_cnt  <= bit_cnt - BIT_W'(1);
              serial_o <= shreg[DATA_BIT-2];
            end else if (last_end) begin
              serial_o <= IDLE_LEVEL;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
            end else begin
              serial_o   <= nbuf[DATA_BIT-1];
              ram_addr_o <= ram_addr_o + ADDR_BIT'(1);
              byte_cnt   <= byte_cnt - ADDR_BIT'(1);
              bit_cnt    <= BIT_W'(DATA_BIT - 1);
              pf_pend    <= 1'b1;
              pf_cnt     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data: shift register and prefetched next-byte buffer
  always_ff @(posedge clk) begin
    if (state == FETCH && fetch_rdy)
      shreg <= ram_q_i;
    else if (state == SHIFT && bit_end)
      shreg <= byte_end ? nbuf : (shreg << 1);
    if (state == SHIFT && pf_take)
      nbuf <= ram_q_i;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Reads a run of pattern bytes from a `pattern_ram` instance and shifts them out on a single serial line. Each bit is held for a programmable number of clock cycles. It is the read-side counterpart of the RAM write path: host logic loads `pattern_ram`, then issues `start_i` here to emit the stored pattern at the selected bit rate. While the current byte is shifting, the next byte is prefetched, so the serial stream has no gaps between bytes.

## Interface

- `DATA_BIT`, default 8: RAM word width and bits per byte shifted.
- `ADDR_BIT`, default 8: RAM address width.
- `DIV_BIT`, default 16: width of the bit-period divisor.
- `RD_LATENCY`, default 1: clock edges from a change on `ram_addr_o` until `ram_q_i` is valid (range 1..4).
- `IDLE_LEVEL`, default 1'b0: level driven on `serial_o` when not transmitting.

Ports:

- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start_i`, input, 1: single-cycle request; ignored while `busy_o`=1.
- `base_addr_i`, input, `ADDR_BIT`: first RAM address; sampled with `start_i`.
- `len_i`, input, `ADDR_BIT`: number of bytes to send; sampled with `start_i`.
- `divisor_i`, input, `DIV_BIT`: clock cycles per bit; sampled with `start_i`; 0 is treated as 1.
- `ram_addr_o`, output, `ADDR_BIT`: registered address to `pattern_ram.address`.
- `ram_q_i`, input, `DATA_BIT`: `pattern_ram.q`.
- `serial_o`, output, 1: serial data, MSB first.
- `busy_o`, output, 1: transfer in progress.
- `done_o`, output, 1: one-cycle pulse at the end of a transfer.

## Operation

- Reset values: `ram_addr_o`=0, `serial_o`=`IDLE_LEVEL`, `busy_o`=0, `done_o`=0. The FSM is in IDLE and all counters are 0.
- The block never writes the RAM; it drives no `wren`.
- **IDLE:**
  - On `start_i` with `len_i`≠0: latch length, divisor (0→1) and base; set `ram_addr_o`=base and `busy_o`=1; go to FETCH.
  - On `start_i` with `len_i`=0: pulse `done_o` for one cycle; `busy_o` stays 0.
- **FETCH:**
  - Wait `RD_LATENCY` edges, then capture `ram_q_i` into the shift register.
  - Drive `serial_o` = bit `DATA_BIT`-1.
  - Advance `ram_addr_o` to the next address (prefetch); go to SHIFT.
- **SHIFT:**
  - Each bit is held for exactly `divisor` cycles. A bit counter counts down `DATA_BIT`-1..0; a byte counter tracks remaining bytes.
  - The prefetched word is captured into a next-byte buffer `RD_LATENCY` edges after the address advance. This always completes before the byte ends, because a byte lasts ≥ `DATA_BIT` cycles and `DATA_BIT` > `RD_LATENCY`.
  - At the end of the last bit's period:
    - If bytes remain: load the buffer into the shift register, put its MSB on `serial_o` with no gap, advance `ram_addr_o`, and stay in SHIFT.
    - Otherwise: `serial_o`=`IDLE_LEVEL`, `busy_o`=0, `done_o`=1 for one cycle; return to IDLE.
- Address arithmetic is modulo 2^`ADDR_BIT`, so 0xFF+1 wraps to 0x00. A transfer of `len_i` bytes may wrap.
- `start_i` asserted in the same cycle that `done_o` is high is ignored; a new start is accepted from the following cycle.
- `rst_n` low mid-transfer aborts immediately to the reset values. No `done_o` is generated.

## Timing

- `start_i` sampled at edge E0: `ram_addr_o`=base and `busy_o`=1 after E0.
- First data bit on `serial_o` after edge E0+`RD_LATENCY`+1. With defaults, that is 2 cycles after the start edge.
- Byte k+1 MSB follows byte k LSB on the next cycle boundary; there are no idle cycles between bytes.
- Total `busy_o` duration = `RD_LATENCY`+1 + `len`×`DATA_BIT`×`divisor` cycles.
- `done_o` rises on the same edge that `busy_o` falls and `serial_o` returns to `IDLE_LEVEL`.
- `ram_addr_o` changes once per byte, at the load edge, and is otherwise stable.

## Test plan

- **Two bytes, divisor 1:** RAM[0]=0xA5, RAM[1]=0x3C; start with base=0, len=2, div=1. Required response: `serial_o` = 1010_0101_0011_1100 on 16 consecutive cycles starting 2 cycles after start; `done_o` pulses once; `busy_o` is high for 18 cycles.
- **Divisor 3:** same data with div=3. Required response: each bit is held exactly 3 cycles (48 data cycles); no gap at the byte boundary.
- **Wrap-around:** RAM[0xFF]=0x81, RAM[0x00]=0x7E; base=0xFF, len=2, div=1. Required response: `ram_addr_o` goes 0xFF, 0x00, 0x01; `serial_o` = 1000_0001_0111_1110.
- **Edge requests:** len=0 must give a `done_o` pulse the next cycle with `busy_o` held low. div=0 must behave identically to div=1.
- **Start while busy:** assert `start_i` with base=0x10 during a transfer from base=0. It must be ignored: data and addresses continue from base 0 and exactly one `done_o` is produced.
- **Reset mid-transfer:** assert `rst_n`=0 during bit 4 of byte 0. Required response: `serial_o`=`IDLE_LEVEL`, `busy_o`=0 and `ram_addr_o`=0 immediately with no `done_o`. After release, a new start transmits correctly.
